rom_access_arbiter: RTL and testbench

//  Shares the single-port instruction ROM between two requesters: core fetch (if_*) and debug/loader reads (dbg_*).

---
 rtl/rom_access_arbiter.sv | 83 ++++++++
 tb/tb_rom_access_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_access_arbiter.sv
// rom_access_arbiter: shares the single-port instruction ROM between core fetch and debug reads.
// Reads issue combinationally on grant; the response returns one cycle later.
module rom_access_arbiter #(
    parameter int ROM_WORDS = 256,
    parameter int PRIO_MODE = 0,
    parameter int MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    input  logic        if_flush,
    output logic        if_rsp_vld,
    output logic [31:0] if_rsp_data,
    output logic        if_rsp_err,
    input  logic        dbg_req,
    input  logic [31:0] dbg_addr,
    output logic        dbg_gnt,
    output logic        dbg_rsp_vld,
    output logic [31:0] dbg_rsp_data,
    output logic        dbg_rsp_err,
    output logic        HSEL1,
    output logic        rd_en_rom,
    output logic [31:0] address_rom,
    input  logic [31:0] instruction
);
    localparam int BW = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
    localparam logic [32:0] LIMIT = 33'(ROM_WORDS) * 33'd4;
    localparam logic [BW-1:0] BMAX = BW'(MAX_BURST);

    typedef enum logic [1:0] {IDLE, RD, ER} state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_dbg_q, last_dbg_d;
    logic [BW-1:0] burst_q, burst_d;
    logic          pick_dbg, gnt, legal;
    logic [31:0]   sel_addr;
    logic          if_own, dbg_own;

    always_comb begin
        pick_dbg   = (PRIO_MODE == 0) ? !last_dbg_q : (burst_q == BMAX);
        dbg_gnt    = !reset && dbg_req && (!if_req || pick_dbg);
        if_gnt     = !reset && if_req && !dbg_gnt;
        gnt        = if_gnt || dbg_gnt;
        sel_addr   = dbg_gnt ? dbg_addr : if_addr;
        legal      = (sel_addr[1:0] == 2'b00) && ({1'b0, sel_addr} < LIMIT);
        state_d    = gnt ? (legal ? RD : ER) : IDLE;
        owner_d    = gnt ? dbg_gnt : owner_q;
        last_dbg_d = gnt ? dbg_gnt : last_dbg_q;
        burst_d    = (!dbg_req || dbg_gnt) ? '0 :
                     (if_gnt && burst_q != BMAX) ? burst_q + BW'(1) : burst_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            last_dbg_q <= 1'b1;
            burst_q    <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_dbg_q <= last_dbg_d;
            burst_q    <= burst_d;
        end
    end

    assign HSEL1       = gnt && legal;
    assign rd_en_rom   = gnt && legal;
    assign address_rom = (gnt && legal) ? sel_addr : 32'd0;

    // A flush only hides the fetch response; the owner and state still advance normally.
    assign if_own       = (state_q != IDLE) && !owner_q && !if_flush;
    assign dbg_own      = (state_q != IDLE) && owner_q;
    assign if_rsp_vld   = if_own;
    assign if_rsp_err   = if_own && (state_q == ER);
    assign if_rsp_data  = (if_own && state_q == RD) ? instruction : 32'd0;
    assign dbg_rsp_vld  = dbg_own;
    assign dbg_rsp_err  = dbg_own && (state_q == ER);
    assign dbg_rsp_data = (dbg_own && state_q == RD) ? instruction : 32'd0;
endmodule

// File: tb/tb_rom_access_arbiter.sv
// tb_rom_access_arbiter: checks round-robin and fixed-priority instances against a cycle-level
// reference model that tracks grants, burst streaks and pending responses directly.
module tb_rom_access_arbiter;
    localparam int MAXB = 4;

    logic        clk = 0, reset = 1;
    logic        if_req = 0, if_flush = 0, dbg_req = 0;
    logic [31:0] if_addr = 0, dbg_addr = 0;
    logic [31:0] mem [256];
    int          tests = 0, fails = 0;

    logic        if_gnt[2], if_vld[2], if_err[2], dbg_gnt[2], dbg_vld[2], dbg_err[2], hsel[2], rd_en[2];
    logic [31:0] if_data[2], dbg_data[2], addr_rom[2], instr[2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        rom_access_arbiter #(.ROM_WORDS(256), .PRIO_MODE(g), .MAX_BURST(MAXB)) u_dut (
            .clk(clk), .reset(reset),
            .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt[g]), .if_flush(if_flush),
            .if_rsp_vld(if_vld[g]), .if_rsp_data(if_data[g]), .if_rsp_err(if_err[g]),
            .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt[g]),
            .dbg_rsp_vld(dbg_vld[g]), .dbg_rsp_data(dbg_data[g]), .dbg_rsp_err(dbg_err[g]),
            .HSEL1(hsel[g]), .rd_en_rom(rd_en[g]), .address_rom(addr_rom[g]), .instruction(instr[g])
        );
        always @(posedge clk) instr[g] <= rd_en[g] ? mem[addr_rom[g][9:2]] : 32'd0;
    end

    function automatic logic [103:0] obs(input int m);
        return {if_gnt[m], dbg_gnt[m], hsel[m], rd_en[m], addr_rom[m], if_vld[m], if_data[m], if_err[m],
                dbg_vld[m], dbg_data[m], dbg_err[m]};
    endfunction

    // Reference model: per instance, who was granted last, fetch streak, and the response owed next cycle.
    logic        m_last_dbg[2], m_pend[2], m_own[2], m_err[2];
    int          m_streak[2];
    logic [31:0] m_data[2];

    function automatic logic gd_f(input int m);
        logic fetch_wins;
        fetch_wins = (m == 0) ? m_last_dbg[m] : (m_streak[m] < MAXB);
        return !reset && dbg_req && !(if_req && fetch_wins);
    endfunction
    function automatic logic gi_f(input int m);
        return !reset && if_req && !gd_f(m);
    endfunction
    function automatic logic [31:0] addr_f(input int m);
        return gd_f(m) ? dbg_addr : if_addr;
    endfunction
    function automatic logic legal_f(input logic [31:0] a);
        return (a % 4 == 0) && (a < 32'd1024);
    endfunction
    function automatic logic [31:0] word_f(input logic [31:0] a);
        return mem[a[9:2]];
    endfunction
    function automatic logic [103:0] exp_vec(input int m);
        logic gi, gd, lg, iv, dv;
        logic [31:0] a;
        gi = gi_f(m);
        gd = gd_f(m);
        a = addr_f(m);
        lg = (gi || gd) && legal_f(a);
        iv = m_pend[m] && !m_own[m] && !if_flush;
        dv = m_pend[m] && m_own[m];
        return {gi, gd, lg, lg, lg ? a : 32'd0, iv, iv ? m_data[m] : 32'd0, iv && m_err[m],
                dv, dv ? m_data[m] : 32'd0, dv && m_err[m]};
    endfunction

    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (reset) begin
                m_pend[m] <= 1'b0;
                m_own[m] <= 1'b0;
                m_last_dbg[m] <= 1'b1;
                m_streak[m] <= 0;
            end else begin
                m_pend[m] <= gi_f(m) || gd_f(m);
                m_own[m] <= gd_f(m);
                m_err[m] <= !legal_f(addr_f(m));
                m_data[m] <= legal_f(addr_f(m)) ? word_f(addr_f(m)) : 32'd0;
                if (gi_f(m) || gd_f(m)) m_last_dbg[m] <= gd_f(m);
                if (!dbg_req || gd_f(m)) m_streak[m] <= 0;
                else if (gi_f(m) && m_streak[m] < MAXB) m_streak[m] <= m_streak[m] + 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_req = 0;
        dbg_req = 0;
        if_flush = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        if_req = 1;
        dbg_req = 1;
        if_addr = 32'h4;
        dbg_addr = 32'h14;
        step();
        step();
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            tests++;
            if (obs(m) !== 104'd0) begin
                fails++;
                $display("FAIL reset[%0d]: got %h expected all zero", m, obs(m));
            end
        end
        reset = 0;
        idle();
        step();
    endtask

    task automatic test_fetch();
        idle();
        if_req = 1;
        if_addr = 32'h4;
        @(negedge clk);
        tests++;
        if (if_gnt[0] !== 1 || addr_rom[0] !== 32'h4 || rd_en[0] !== 1 || obs(1) !== exp_vec(1)) begin
            fails++;
            $display("FAIL fetch_issue: gnt=%b addr=%h rd=%b expected 1/00000004/1", if_gnt[0], addr_rom[0], rd_en[0]);
        end
        step();
        if_addr = 32'h8;
        @(negedge clk);
        tests++;
        if (if_vld[0] !== 1 || if_data[0] !== 32'h00208113 || addr_rom[0] !== 32'h8 || obs(1) !== exp_vec(1)) begin
            fails++;
            $display("FAIL fetch_b2b_1: vld=%b data=%h addr=%h expected 1/00208113/00000008", if_vld[0], if_data[0], addr_rom[0]);
        end
        step();
        if_req = 0;
        @(negedge clk);
        tests++;
        if (if_vld[0] !== 1 || if_data[0] !== 32'h00308193 || if_err[0] !== 0 || obs(1) !== exp_vec(1)) begin
            fails++;
            $display("FAIL fetch_b2b_2: vld=%b data=%h err=%b expected 1/00308193/0", if_vld[0], if_data[0], if_err[0]);
        end
        step();
    endtask

    task automatic test_contention();
        reset = 1;
        idle();
        step();
        reset = 0;
        if_req = 1;
        dbg_req = 1;
        if_addr = 32'h4;
        dbg_addr = 32'h14;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            tests++;
            if (obs(0) !== exp_vec(0) || obs(1) !== exp_vec(1) ||
                dbg_gnt[0] !== logic'(k % 2 == 1) || if_gnt[0] !== logic'(k % 2 == 0) ||
                dbg_gnt[1] !== logic'(k % 5 == 4) || if_gnt[1] !== logic'(k % 5 != 4)) begin
                fails++;
                $display("FAIL contention k=%0d: rr if/dbg=%b%b prio if/dbg=%b%b", k, if_gnt[0], dbg_gnt[0], if_gnt[1], dbg_gnt[1]);
            end
            if (k == 2) begin
                tests++;
                if (dbg_vld[0] !== 1 || dbg_data[0] !== 32'h003102B3) begin
                    fails++;
                    $display("FAIL contention_dbg_data: vld=%b data=%h expected 1/003102b3", dbg_vld[0], dbg_data[0]);
                end
            end
            step();
        end
        idle();
        step();
    endtask

    task automatic test_errors();
        logic [31:0] bad [2];
        bad[0] = 32'h6;
        bad[1] = 32'h400;
        for (int i = 0; i < 2; i++) begin
            idle();
            dbg_req = 1;
            dbg_addr = bad[i];
            @(negedge clk);
            tests++;
            if (dbg_gnt[0] !== 1 || rd_en[0] !== 0 || hsel[0] !== 0 || addr_rom[0] !== 0 || obs(1) !== exp_vec(1)) begin
                fails++;
                $display("FAIL err_issue %h: gnt=%b rd=%b hsel=%b addr=%h expected 1/0/0/0", bad[i], dbg_gnt[0], rd_en[0], hsel[0], addr_rom[0]);
            end
            step();
            dbg_req = 0;
            @(negedge clk);
            tests++;
            if (dbg_vld[0] !== 1 || dbg_err[0] !== 1 || dbg_data[0] !== 0 || if_vld[0] !== 0 || obs(1) !== exp_vec(1)) begin
                fails++;
                $display("FAIL err_rsp %h: vld=%b err=%b data=%h expected 1/1/0", bad[i], dbg_vld[0], dbg_err[0], dbg_data[0]);
            end
            step();
        end
    endtask

    task automatic test_flush();
        idle();
        if_req = 1;
        if_addr = 32'h8;
        step();
        if_req = 0;
        if_flush = 1;
        @(negedge clk);
        tests++;
        if (if_vld[0] !== 0 || if_err[0] !== 0 || if_vld[1] !== 0 || obs(0) !== exp_vec(0)) begin
            fails++;
            $display("FAIL flush: vld=%b/%b err=%b expected 0/0/0", if_vld[0], if_vld[1], if_err[0]);
        end
        step();
        idle();
        reset = 1;
        if_req = 1;
        @(negedge clk);
        tests++;
        if (if_gnt[0] !== 0 || rd_en[0] !== 0) begin
            fails++;
            $display("FAIL reset_gnt: gnt=%b rd=%b expected 0/0", if_gnt[0], rd_en[0]);
        end
        step();
        reset = 0;
        if_req = 0;
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            tests++;
            if (obs(m) !== 104'd0) begin
                fails++;
                $display("FAIL reset_issue[%0d]: got %h expected all zero", m, obs(m));
            end
        end
        step();
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            reset = ($urandom_range(0, 49) == 0);
            if_req = $urandom_range(0, 2) != 0;
            dbg_req = $urandom_range(0, 2) != 0;
            if_flush = $urandom_range(0, 3) == 0;
            if_addr = ($urandom_range(0, 4) == 0) ? $urandom() : {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            dbg_addr = ($urandom_range(0, 4) == 0) ? $urandom() : {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                tests++;
                if (obs(m) !== exp_vec(m)) begin
                    fails++;
                    $display("FAIL random k=%0d dut%0d: got %h expected %h", k, m, obs(m), exp_vec(m));
                end
            end
            step();
        end
        reset = 0;
        idle();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom();
        mem[1] = 32'h00208113;
        mem[2] = 32'h00308193;
        mem[5] = 32'h003102B3;
        #1;
        test_reset();
        test_fetch();
        test_contention();
        test_errors();
        test_flush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
